// File: rtl/pixel_window_pkg.sv
// Shared types and sizing helpers for the pixel window loader.
package pixel_window_pkg;

  typedef enum logic {
    PAD_VALID = 1'b0,
    PAD_ZERO  = 1'b1
  } pad_mode_e;

  typedef enum logic {
    STREAM = 1'b0,
    DRAIN  = 1'b1
  } state_e;

  // Window radius R for an odd kernel edge length.
  function automatic int unsigned radius(input int unsigned ksize);
    return (ksize - 1) / 2;
  endfunction

  // Bits needed to hold a counter ranging over 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_window_loader_line_delay.sv
// One image line of delay: the output is the item pushed DEPTH enabled steps ago.
// Contents are deliberately not reset; the loader masks anything stale.
module line_delay #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 512
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Shift the whole line by one slot on each enabled step.
  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/pixel_window_loader.sv
// Raster stream to KSIZE x KSIZE neighbourhood windows, valid-only or zero-padded.
module pixel_window_loader
  import pixel_window_pkg::*;
#(
  parameter int unsigned ITEM_SIZE  = 8,
  parameter int unsigned IMG_WIDTH  = 512,
  parameter int unsigned IMG_HEIGHT = 512,
  parameter int unsigned KSIZE      = 3,
  parameter int unsigned PAD_MODE   = 0
) (
  input  logic                                 clk,
  input  logic                                 rstN,
  input  logic [ITEM_SIZE-1:0]                 pixel_in,
  input  logic                                 pixel_in_valid,
  output logic                                 pixel_in_ready,
  output logic [KSIZE*KSIZE*ITEM_SIZE-1:0]     window_out,
  output logic                                 window_out_valid,
  output logic [cnt_width(IMG_WIDTH)-1:0]      window_x,
  output logic [cnt_width(IMG_HEIGHT)-1:0]     window_y,
  output logic                                 frame_done
);

  localparam int R   = int'(radius(KSIZE));
  localparam int K   = int'(KSIZE);
  localparam int W   = int'(IMG_WIDTH);
  localparam int H   = int'(IMG_HEIGHT);
  localparam int XW  = int'(cnt_width(IMG_WIDTH));
  localparam int YW  = int'(cnt_width(IMG_HEIGHT));
  // in_y runs past the last line while the drain injects virtual rows.
  localparam int CYW = int'(cnt_width(IMG_HEIGHT + radius(KSIZE) + 1));
  localparam bit PadZero = (PAD_MODE == 32'(PAD_ZERO));

  state_e               state_q, state_d;
  logic [XW-1:0]        in_x_q, in_x_d;
  logic [CYW-1:0]       in_y_q, in_y_d;
  logic                 step, emit, last;
  int                   cx, cy;
  logic [ITEM_SIZE-1:0] item;
  logic [ITEM_SIZE-1:0] tap [KSIZE];
  logic [ITEM_SIZE-1:0] win_q [KSIZE][KSIZE];
  logic                 valid_q, done_q;
  logic [XW-1:0]        wx_q;
  logic [YW-1:0]        wy_q;

  assign pixel_in_ready = (state_q == STREAM);
  assign step = (state_q == DRAIN) || pixel_in_valid;
  assign item = (state_q == DRAIN) ? '0 : pixel_in;

  // tap[K-1] is the current item; tap[r] for r < K-1 is the same column K-1-r lines up.
  assign tap[KSIZE-1] = item;
  for (genvar g = 0; g < KSIZE - 1; g++) begin : g_lines
    line_delay #(
      .WIDTH(ITEM_SIZE),
      .DEPTH(IMG_WIDTH)
    ) u_line (
      .clk (clk),
      .en  (step),
      .din (tap[KSIZE-1-g]),
      .dout(tap[KSIZE-2-g])
    );
  end

  // Next-state: stream position, drain control and window emission decode.
  always_comb begin
    state_d = state_q;
    in_x_d  = in_x_q;
    in_y_d  = in_y_q;
    emit    = 1'b0;
    last    = 1'b0;
    // Centre lags the stream by R lines and R columns, borrowing a line at the left edge.
    if (int'(in_x_q) >= R) begin
      cx = int'(in_x_q) - R;
      cy = int'(in_y_q) - R;
    end else begin
      cx = int'(in_x_q) + W - R;
      cy = int'(in_y_q) - R - 1;
    end
    if (step) begin
      if (int'(in_x_q) == W - 1) begin
        in_x_d = '0;
        in_y_d = in_y_q + CYW'(1);
      end else begin
        in_x_d = in_x_q + XW'(1);
      end
      if (PadZero) begin
        emit = (int'(in_y_q) > R) || (int'(in_y_q) == R && int'(in_x_q) >= R);
        if (state_q == STREAM && int'(in_x_q) == W - 1 && int'(in_y_q) == H - 1) begin
          state_d = DRAIN;
        end
        if (state_q == DRAIN && int'(in_x_q) == R - 1 && int'(in_y_q) == H + R) begin
          state_d = STREAM;
          in_x_d  = '0;
          in_y_d  = '0;
          last    = 1'b1;
        end
      end else begin
        emit = (int'(in_x_q) >= K - 1) && (int'(in_y_q) >= K - 1);
        if (int'(in_x_q) == W - 1 && int'(in_y_q) == H - 1) begin
          in_y_d = '0;
          last   = 1'b1;
        end
      end
    end
  end

  // State and stream counters.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= STREAM;
      in_x_q  <= '0;
      in_y_q  <= '0;
    end else begin
      state_q <= state_d;
      in_x_q  <= in_x_d;
      in_y_q  <= in_y_d;
    end
  end

  // Sliding window: shift left and load the fresh right-hand column.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (step) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE - 1; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
        win_q[r][KSIZE-1] <= tap[r];
      end
    end
  end

  // Output strobe, frame-end pulse and centre coordinates.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      wx_q    <= '0;
      wy_q    <= '0;
    end else begin
      valid_q <= emit;
      done_q  <= emit && last;
      if (emit) begin
        wx_q <= XW'(cx);
        wy_q <= YW'(cy);
      end
    end
  end

  // Zero elements that fall outside the image, including wrapped columns.
  always_comb begin
    window_out = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        if (!PadZero ||
            ((int'(wx_q) - R + c) >= 0 && (int'(wx_q) - R + c) < W &&
             (int'(wy_q) - R + r) >= 0 && (int'(wy_q) - R + r) < H)) begin
          window_out[(r*KSIZE+c)*ITEM_SIZE +: ITEM_SIZE] = win_q[r][c];
        end
      end
    end
  end

  assign window_out_valid = valid_q;
  assign frame_done       = done_q;
  assign window_x         = wx_q;
  assign window_y         = wy_q;

endmodule

// File: tb/tb_pixel_window_loader.sv
// Directed scoreboard bench: three loader instances (valid K3, pad K3, valid K5).
`timescale 1ns/1ps
module tb_pixel_window_loader;

  localparam int W = 8;

  typedef struct {
    logic [391:0] win;
    int           x;
    int           y;
    bit           done;
    int           cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstN;
  logic [7:0] pix;
  logic       vld;
  int         sel;

  logic [71:0]  v_win, p_win;
  logic [199:0] k_win;
  logic         v_valid, p_valid, k_valid, v_done, p_done, k_done, v_rdy, p_rdy, k_rdy;
  logic [2:0]   v_x, v_y, p_x, p_y, k_x, k_y;

  exp_t q0[$], q1[$], q2[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   wcnt[3];
  int   dcnt[3];

  always #5 clk = ~clk;

  pixel_window_loader #(.ITEM_SIZE(8), .IMG_WIDTH(8), .IMG_HEIGHT(6), .KSIZE(3), .PAD_MODE(0))
  dut_v (.clk(clk), .rstN(rstN), .pixel_in(pix), .pixel_in_valid(vld && sel == 0),
         .pixel_in_ready(v_rdy), .window_out(v_win), .window_out_valid(v_valid),
         .window_x(v_x), .window_y(v_y), .frame_done(v_done));

  pixel_window_loader #(.ITEM_SIZE(8), .IMG_WIDTH(8), .IMG_HEIGHT(6), .KSIZE(3), .PAD_MODE(1))
  dut_p (.clk(clk), .rstN(rstN), .pixel_in(pix), .pixel_in_valid(vld && sel == 1),
         .pixel_in_ready(p_rdy), .window_out(p_win), .window_out_valid(p_valid),
         .window_x(p_x), .window_y(p_y), .frame_done(p_done));

  pixel_window_loader #(.ITEM_SIZE(8), .IMG_WIDTH(8), .IMG_HEIGHT(8), .KSIZE(5), .PAD_MODE(0))
  dut_k (.clk(clk), .rstN(rstN), .pixel_in(pix), .pixel_in_valid(vld && sel == 2),
         .pixel_in_ready(k_rdy), .window_out(k_win), .window_out_valid(k_valid),
         .window_x(k_x), .window_y(k_y), .frame_done(k_done));

  function automatic int k_of(input int d);
    return (d == 2) ? 5 : 3;
  endfunction

  function automatic int h_of(input int d);
    return (d == 2) ? 8 : 6;
  endfunction

  function automatic logic ready_of(input int d);
    case (d)
      0:       return v_rdy;
      1:       return p_rdy;
      default: return k_rdy;
    endcase
  endfunction

  // Reference window: item (x,y) = base + y*16 + x, zero outside the image.
  function automatic logic [391:0] exp_win(input int base, input int k, input int hh,
                                           input int cx, input int cy);
    logic [391:0] w;
    int r, x, y;
    w = '0;
    r = k / 2;
    for (int rr = 0; rr < k; rr++) begin
      for (int cc = 0; cc < k; cc++) begin
        x = cx - r + cc;
        y = cy - r + rr;
        if (x >= 0 && x < W && y >= 0 && y < hh) w[(rr*k+cc)*8 +: 8] = 8'((base + y*16 + x) & 255);
      end
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [391:0] obs, input logic [391:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic push(input int d, input int base, input int cx, input int cy, input int at);
    exp_t e;
    e.win  = exp_win(base, k_of(d), h_of(d), cx, cy);
    e.x    = cx;
    e.y    = cy;
    e.done = (d == 1) ? (cx == W - 1 && cy == h_of(d) - 1)
                      : (cx == W - 1 - k_of(d) / 2 && cy == h_of(d) - 1 - k_of(d) / 2);
    e.cyc  = at;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Compare every instance's outputs against its scoreboard head.
  task automatic check_outputs();
    for (int d = 0; d < 3; d++) begin
      logic         ov, od, have;
      logic [391:0] ow;
      int           ox, oy, qs;
      exp_t         e;
      case (d)
        0: begin ov = v_valid; od = v_done; ow = 392'(v_win); ox = int'(v_x); oy = int'(v_y); qs = q0.size(); end
        1: begin ov = p_valid; od = p_done; ow = 392'(p_win); ox = int'(p_x); oy = int'(p_y); qs = q1.size(); end
        default: begin ov = k_valid; od = k_done; ow = 392'(k_win); ox = int'(k_x); oy = int'(k_y); qs = q2.size(); end
      endcase
      have = (qs != 0);
      if (have) begin
        case (d)
          0:       e = q0[0];
          1:       e = q1[0];
          default: e = q2[0];
        endcase
      end
      if (ov) begin
        wcnt[d]++;
        if (od) dcnt[d]++;
        checks++;
        assert (have === 1'b1) else begin
          errors++;
          $error("FAIL unexpected_window dut=%0d observed=valid expected=no window (cycle %0d)", d, cyc);
        end
        if (have) begin
          chk($sformatf("win_cycle%0d", d), 392'(cyc), 392'(e.cyc));
          chk($sformatf("win_data%0d", d), ow, e.win);
          chk($sformatf("win_x%0d", d), 392'(ox), 392'(e.x));
          chk($sformatf("win_y%0d", d), 392'(oy), 392'(e.y));
          chk($sformatf("frame_done%0d", d), 392'(od), 392'(e.done));
        end
      end else if (have && e.cyc <= cyc) begin
        chk($sformatf("missing_window%0d", d), 392'(ov), 392'(1));
      end
      if ((ov || (have && e.cyc <= cyc)) && have) begin
        case (d)
          0:       void'(q0.pop_front());
          1:       void'(q1.pop_front());
          default: void'(q2.pop_front());
        endcase
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    repeat (n) tick();
  endtask

  // Drive up to nitems of a frame to instance d; valid is left high at the end.
  task automatic drive_frame(input int d, input int base, input bit gaps, input int nitems);
    int  k, hh, r, s, cs, n, g, cnt;
    bit  acc, rdy;
    k   = k_of(d);
    hh  = h_of(d);
    r   = k / 2;
    cnt = 0;
    sel = d;
    for (int y = 0; y < hh; y++) begin
      for (int x = 0; x < W; x++) begin
        if (cnt < nitems) begin
          g = 0;
          while (gaps && g < 6 && $urandom_range(1, 0) == 1) begin
            vld = 1'b0;
            tick();
            g++;
          end
          pix = 8'((base + y*16 + x) & 255);
          vld = 1'b1;
          acc = 1'b0;
          n   = 0;
          while (!acc && n < 100) begin
            rdy = ready_of(d);
            if (rdy) begin
              s = y*W + x;
              if (d == 1) begin
                cs = s - (r*W + r);
                if (cs >= 0) push(d, base, cs % W, cs / W, cyc + 1);
              end else if (x >= k - 1 && y >= k - 1) begin
                push(d, base, x - r, y - r, cyc + 1);
              end
            end
            tick();
            acc = rdy;
            n++;
          end
          checks++;
          assert (acc === 1'b1) else begin
            errors++;
            $error("FAIL accept_timeout dut=%0d observed=not accepted expected=accepted", d);
          end
          cnt++;
        end
      end
    end
    if (d == 1 && cnt == W*hh) begin
      for (int j = 1; j <= r*W + r; j++) begin
        cs = W*hh - 1 + j - (r*W + r);
        push(d, base, cs % W, cs / W, cyc + j);
      end
      // Keep valid high with junk during the drain; none of it may be taken.
      pix = 8'hEE;
      n   = 0;
      while (!ready_of(d) && n < 100) begin
        tick();
        n++;
      end
      chk("drain_ready_low_cycles", 392'(n), 392'(r*W + r));
    end
  endtask

  task automatic check_reset_state();
    chk("rst_valid", 392'(v_valid), 392'(0));
    chk("rst_done", 392'(v_done), 392'(0));
    chk("rst_window", 392'(v_win), 392'(0));
    chk("rst_x", 392'(v_x), 392'(0));
    chk("rst_y", 392'(v_y), 392'(0));
    chk("rst_ready_v", 392'(v_rdy), 392'(1));
    chk("rst_ready_p", 392'(p_rdy), 392'(1));
  endtask

  initial begin
    rstN = 1'b0;
    vld  = 1'b0;
    pix  = '0;
    sel  = 0;
    for (int i = 0; i < 3; i++) begin
      wcnt[i] = 0;
      dcnt[i] = 0;
    end
    tick();
    tick();
    check_reset_state();
    rstN = 1'b1;

    // Valid-only ramp frame.
    drive_frame(0, 0, 1'b0, 1000);
    idle(3);
    chk("s1_windows", 392'(wcnt[0]), 392'(24));
    chk("s1_frame_done", 392'(dcnt[0]), 392'(1));

    // Zero-padded frames; the second one follows a drain with valid held high.
    drive_frame(1, 0, 1'b0, 1000);
    drive_frame(1, 8'h80, 1'b0, 1000);
    idle(3);
    chk("s2_windows", 392'(wcnt[1]), 392'(96));
    chk("s2_frame_done", 392'(dcnt[1]), 392'(2));

    // Valid-only with random valid gaps.
    drive_frame(0, 0, 1'b1, 1000);
    idle(3);
    chk("s3_windows", 392'(wcnt[0]), 392'(48));
    chk("s3_frame_done", 392'(dcnt[0]), 392'(2));

    // Two back-to-back valid-only frames.
    drive_frame(0, 0, 1'b0, 1000);
    drive_frame(0, 8'h80, 1'b0, 1000);
    idle(3);
    chk("s4_windows", 392'(wcnt[0]), 392'(96));
    chk("s4_frame_done", 392'(dcnt[0]), 392'(4));

    // Reset mid-frame after 20 items, then a full frame.
    drive_frame(0, 0, 1'b0, 20);
    idle(3);
    rstN = 1'b0;
    tick();
    check_reset_state();
    rstN = 1'b1;
    drive_frame(0, 0, 1'b0, 1000);
    idle(3);
    chk("s5_windows", 392'(wcnt[0]), 392'(96 + 2 + 24));
    chk("s5_frame_done", 392'(dcnt[0]), 392'(5));

    // K=5 valid-only.
    drive_frame(2, 0, 1'b0, 1000);
    idle(3);
    chk("s6_windows", 392'(wcnt[2]), 392'(16));
    chk("s6_frame_done", 392'(dcnt[2]), 392'(1));

    chk("pending_v", 392'(q0.size()), 392'(0));
    chk("pending_p", 392'(q1.size()), 392'(0));
    chk("pending_k", 392'(q2.size()), 392'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
